led_snake_top_ctrl: RTL and testbench

LED_SNAKE_TOP_CTRL -- requirements
Module: led_snake_top

---
 rtl/led_snake_top_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_led_snake_top_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_snake_top_ctrl.sv
// One-wire LED strip refresher: streams eight 24-bit colour words MSB first using
// pulse-width bit encoding, each refresh preceded by a long low latch period.
module led_snake_top_ctrl #(
    parameter int L_TIME = 80,
    parameter int S_TIME = 40,
    parameter int R_TIME = 5000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] led0,
    input  logic [23:0] led1,
    input  logic [23:0] led2,
    input  logic [23:0] led3,
    input  logic [23:0] led4,
    input  logic [23:0] led5,
    input  logic [23:0] led6,
    input  logic [23:0] led7,
    output logic        led_stripe_pin,
    output logic        new_frames_set_rqst,
    output logic [23:0] frame_to_transmit_dbg,
    output logic [2:0]  no_of_frame_dbg,
    output logic        r_time_wait_dbg,
    output logic        l_time_wait_dbg,
    output logic        s_time_wait_dbg,
    output logic        reset_finish_dbg,
    output logic        l_time_measured_dbg,
    output logic        s_time_measured_dbg,
    output logic [15:0] r_time_cnt_dbg,
    output logic [15:0] l_time_cnt_dbg,
    output logic [15:0] s_time_cnt_dbg
);

    typedef enum logic [1:0] {
        RST_LOW  = 2'd0,
        BIT_HIGH = 2'd1,
        BIT_LOW  = 2'd2,
        REQ      = 2'd3
    } state_t;

    localparam logic [15:0] L_LAST = 16'(L_TIME - 1);
    localparam logic [15:0] S_LAST = 16'(S_TIME - 1);
    localparam logic [15:0] R_LAST = 16'(R_TIME - 1);

    state_t       state_r, state_s;
    logic [15:0]  r_cnt_r, r_cnt_s;
    logic [15:0]  l_cnt_r, l_cnt_s;
    logic [15:0]  s_cnt_r, s_cnt_s;
    logic [4:0]   bit_idx_r, bit_idx_s;
    logic [2:0]   frame_idx_r, frame_idx_s;
    logic [23:0]  frame_r, frame_s;
    logic [7:0][23:0] led_arr_s;

    logic         cur_bit_s;
    logic         long_phase_s;
    logic         phase_done_s;
    logic         next_bit_s;
    logic         l_wait_s;
    logic         s_wait_s;

    logic         pin_r;
    logic         rqst_r;
    logic         r_wait_r;
    logic         l_wait_r;
    logic         s_wait_r;
    logic         r_fin_r;
    logic         l_meas_r;
    logic         s_meas_r;

    assign led_arr_s = {led7, led6, led5, led4, led3, led2, led1, led0};

    // State register: sequencer state, phase counters and the frame being shifted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= RST_LOW;
            r_cnt_r     <= 16'd0;
            l_cnt_r     <= 16'd0;
            s_cnt_r     <= 16'd0;
            bit_idx_r   <= 5'd23;
            frame_idx_r <= 3'd0;
            frame_r     <= 24'd0;
        end else begin
            state_r     <= state_s;
            r_cnt_r     <= r_cnt_s;
            l_cnt_r     <= l_cnt_s;
            s_cnt_r     <= s_cnt_s;
            bit_idx_r   <= bit_idx_s;
            frame_idx_r <= frame_idx_s;
            frame_r     <= frame_s;
        end
    end

    // Next-state logic: latch period, two-phase bit cells, frame stepping and request.
    always_comb begin
        state_s      = state_r;
        r_cnt_s      = r_cnt_r;
        l_cnt_s      = l_cnt_r;
        s_cnt_s      = s_cnt_r;
        bit_idx_s    = bit_idx_r;
        frame_idx_s  = frame_idx_r;
        frame_s      = frame_r;
        cur_bit_s    = frame_r[bit_idx_r];
        long_phase_s = 1'b0;
        phase_done_s = 1'b0;
        case (state_r)
            RST_LOW: begin
                // r_wait_r is low only on the first edge after reset release, which holds the count at 0.
                if (r_wait_r) begin
                    if (r_cnt_r == R_LAST) begin
                        r_cnt_s     = 16'd0;
                        state_s     = BIT_HIGH;
                        bit_idx_s   = 5'd23;
                        frame_idx_s = 3'd0;
                        frame_s     = led_arr_s[3'd0];
                    end else begin
                        r_cnt_s = r_cnt_r + 16'd1;
                    end
                end else begin
                    r_cnt_s = 16'd0;
                end
            end
            BIT_HIGH, BIT_LOW: begin
                long_phase_s = (state_r == BIT_HIGH) ? cur_bit_s : ~cur_bit_s;
                if (long_phase_s) begin
                    phase_done_s = (l_cnt_r == L_LAST);
                    l_cnt_s      = phase_done_s ? 16'd0 : l_cnt_r + 16'd1;
                end else begin
                    phase_done_s = (s_cnt_r == S_LAST);
                    s_cnt_s      = phase_done_s ? 16'd0 : s_cnt_r + 16'd1;
                end
                if (!phase_done_s) begin
                    state_s = state_r;
                end else if (state_r == BIT_HIGH) begin
                    state_s = BIT_LOW;
                end else if (bit_idx_r != 5'd0) begin
                    bit_idx_s = bit_idx_r - 5'd1;
                    state_s   = BIT_HIGH;
                end else if (frame_idx_r == 3'd7) begin
                    frame_idx_s = 3'd0;
                    state_s     = REQ;
                end else begin
                    frame_idx_s = frame_idx_r + 3'd1;
                    bit_idx_s   = 5'd23;
                    frame_s     = led_arr_s[frame_idx_r + 3'd1];
                    state_s     = BIT_HIGH;
                end
            end
            REQ: begin
                r_cnt_s = 16'd0;
                state_s = RST_LOW;
            end
            default: begin
                state_s = RST_LOW;
            end
        endcase
    end

    // Output decode of the upcoming state so every pin and flag comes straight from a flop.
    always_comb begin
        next_bit_s = frame_s[bit_idx_s];
        l_wait_s   = 1'b0;
        s_wait_s   = 1'b0;
        case (state_s)
            BIT_HIGH: begin
                l_wait_s = next_bit_s;
                s_wait_s = ~next_bit_s;
            end
            BIT_LOW: begin
                l_wait_s = ~next_bit_s;
                s_wait_s = next_bit_s;
            end
            default: begin
                l_wait_s = 1'b0;
                s_wait_s = 1'b0;
            end
        endcase
    end

    // Output register: pin, request pulse and phase status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pin_r    <= 1'b0;
            rqst_r   <= 1'b0;
            r_wait_r <= 1'b0;
            l_wait_r <= 1'b0;
            s_wait_r <= 1'b0;
            r_fin_r  <= 1'b0;
            l_meas_r <= 1'b0;
            s_meas_r <= 1'b0;
        end else begin
            pin_r    <= (state_s == BIT_HIGH);
            rqst_r   <= (state_s == REQ);
            r_wait_r <= (state_s == RST_LOW);
            l_wait_r <= l_wait_s;
            s_wait_r <= s_wait_s;
            r_fin_r  <= (state_s == RST_LOW) && (r_cnt_s == R_LAST);
            l_meas_r <= l_wait_s && (l_cnt_s == L_LAST);
            s_meas_r <= s_wait_s && (s_cnt_s == S_LAST);
        end
    end

    assign led_stripe_pin        = pin_r;
    assign new_frames_set_rqst   = rqst_r;
    assign frame_to_transmit_dbg = frame_r;
    assign no_of_frame_dbg       = frame_idx_r;
    assign r_time_wait_dbg       = r_wait_r;
    assign l_time_wait_dbg       = l_wait_r;
    assign s_time_wait_dbg       = s_wait_r;
    assign reset_finish_dbg      = r_fin_r;
    assign l_time_measured_dbg   = l_meas_r;
    assign s_time_measured_dbg   = s_meas_r;
    assign r_time_cnt_dbg        = r_cnt_r;
    assign l_time_cnt_dbg        = l_cnt_r;
    assign s_time_cnt_dbg        = s_cnt_r;

endmodule

// File: tb/tb_led_snake_top_ctrl.sv
// Bench for led_snake_top_ctrl: decodes the pin waveform into bits and compares against
// the colour words the strip should receive, plus latch timing and reset behaviour.
module tb_led_snake_top_ctrl;

    localparam int L       = 80;
    localparam int S       = 40;
    localparam int R       = 5000;
    localparam int BIT_CYC = L + S;
    localparam int REFRESH = R + 8 * 24 * BIT_CYC;
    localparam int CAP     = 2 * BIT_CYC;

    logic        clk;
    logic        rstn;
    logic [23:0] led [8];
    logic        led_stripe_pin, new_frames_set_rqst;
    logic [23:0] frame_to_transmit_dbg;
    logic [2:0]  no_of_frame_dbg;
    logic        r_time_wait_dbg, l_time_wait_dbg, s_time_wait_dbg;
    logic        reset_finish_dbg, l_time_measured_dbg, s_time_measured_dbg;
    logic [15:0] r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;
    int rq_seen  = 0;
    int start_ncyc = 0;
    logic [23:0] exp_led [8];

    led_snake_top_ctrl #(.L_TIME(L), .S_TIME(S), .R_TIME(R)) dut (
        .clk(clk), .rstn(rstn),
        .led0(led[0]), .led1(led[1]), .led2(led[2]), .led3(led[3]),
        .led4(led[4]), .led5(led[5]), .led6(led[6]), .led7(led[7]),
        .led_stripe_pin(led_stripe_pin),
        .new_frames_set_rqst(new_frames_set_rqst),
        .frame_to_transmit_dbg(frame_to_transmit_dbg),
        .no_of_frame_dbg(no_of_frame_dbg),
        .r_time_wait_dbg(r_time_wait_dbg),
        .l_time_wait_dbg(l_time_wait_dbg),
        .s_time_wait_dbg(s_time_wait_dbg),
        .reset_finish_dbg(reset_finish_dbg),
        .l_time_measured_dbg(l_time_measured_dbg),
        .s_time_measured_dbg(s_time_measured_dbg),
        .r_time_cnt_dbg(r_time_cnt_dbg),
        .l_time_cnt_dbg(l_time_cnt_dbg),
        .s_time_cnt_dbg(s_time_cnt_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (new_frames_set_rqst === 1'b1) rq_seen <= rq_seen + 1;
    end

    // Length of the high run then the low run of one bit cell, starting on its first high sample.
    task automatic measure_bit(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (led_stripe_pin === 1'b1 && hi < CAP) begin
            hi++;
            @(negedge clk);
        end
        while (led_stripe_pin === 1'b0 && new_frames_set_rqst !== 1'b1 && lo < CAP) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic receive_bits(input int top, output logic [23:0] word, output int malformed);
        int hi, lo;
        word = 24'h0;
        malformed = 0;
        for (int b = top; b >= 0; b--) begin
            measure_bit(hi, lo);
            if (hi == L && lo == S) word[b] = 1'b1;
            else if (hi == S && lo == L) word[b] = 1'b0;
            else malformed++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({led_stripe_pin, new_frames_set_rqst} !== 2'b00)
            $display("FAIL reset_pin_rqst: got %b required 00", {led_stripe_pin, new_frames_set_rqst});
        else n_pass++;
        n_checks++;
        if (frame_to_transmit_dbg !== 24'h0 || no_of_frame_dbg !== 3'd0)
            $display("FAIL reset_frame: got %h/%0d required 000000/0", frame_to_transmit_dbg, no_of_frame_dbg);
        else n_pass++;
        n_checks++;
        if ({r_time_wait_dbg, l_time_wait_dbg, s_time_wait_dbg} !== 3'b000)
            $display("FAIL reset_wait: got %b required 000", {r_time_wait_dbg, l_time_wait_dbg, s_time_wait_dbg});
        else n_pass++;
        n_checks++;
        if ({reset_finish_dbg, l_time_measured_dbg, s_time_measured_dbg} !== 3'b000)
            $display("FAIL reset_measured: got %b required 000", {reset_finish_dbg, l_time_measured_dbg, s_time_measured_dbg});
        else n_pass++;
        n_checks++;
        if ({r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg} !== 48'h0)
            $display("FAIL reset_counters: got %h required 0", {r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg});
        else n_pass++;
        #1 rstn = 1'b1;
        @(negedge clk);
        start_ncyc = ncyc;
        n_checks++;
        if ({r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL release_start: got wait=%b pin=%b cnt=%0d required 1/0/0", r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg);
        else n_pass++;
    endtask

    task automatic test_rst_low();
        int bad = 0;
        int first_bad = -1;
        for (int k = 0; k < R; k++) begin
            if (led_stripe_pin !== 1'b0 || r_time_wait_dbg !== 1'b1 || r_time_cnt_dbg !== 16'(k) ||
                reset_finish_dbg !== (k == R - 1) || l_time_wait_dbg !== 1'b0 ||
                s_time_wait_dbg !== 1'b0 || new_frames_set_rqst !== 1'b0) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) $display("FAIL rst_low_phase: %0d bad cycles (first %0d) required 0", bad, first_bad);
        else n_pass++;
        n_checks++;
        if (led_stripe_pin !== 1'b1) $display("FAIL rst_low_length: pin=%b at cycle %0d required 1", led_stripe_pin, R);
        else n_pass++;
    endtask

    task automatic test_first_bits();
        logic [23:0] w;
        logic [23:0] rest;
        int bad = 0;
        int hi, lo, mal;
        w = exp_led[0];
        n_checks++;
        if (frame_to_transmit_dbg !== w || no_of_frame_dbg !== 3'd0)
            $display("FAIL first_frame_load: got %h/%0d required %h/0", frame_to_transmit_dbg, no_of_frame_dbg, w);
        else n_pass++;
        // leading '0' bit: short high on the S counter, then long low on the L counter
        for (int k = 0; k < S; k++) begin
            if (led_stripe_pin !== 1'b1 || s_time_wait_dbg !== 1'b1 || l_time_wait_dbg !== 1'b0 ||
                s_time_cnt_dbg !== 16'(k) || s_time_measured_dbg !== (k == S - 1) || l_time_measured_dbg !== 1'b0)
                bad++;
            @(negedge clk);
        end
        for (int k = 0; k < L; k++) begin
            if (led_stripe_pin !== 1'b0 || l_time_wait_dbg !== 1'b1 || s_time_wait_dbg !== 1'b0 ||
                l_time_cnt_dbg !== 16'(k) || l_time_measured_dbg !== (k == L - 1) || s_time_measured_dbg !== 1'b0)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bit23_phases: %0d bad cycles required 0", bad);
        else n_pass++;
        for (int b = 22; b >= 20; b--) begin
            measure_bit(hi, lo);
            n_checks++;
            if (hi !== (w[b] ? L : S) || lo !== (w[b] ? S : L))
                $display("FAIL bit%0d_timing: got high %0d low %0d required %0d/%0d", b, hi, lo, w[b] ? L : S, w[b] ? S : L);
            else n_pass++;
        end
        receive_bits(19, rest, mal);
        n_checks++;
        if (rest[19:0] !== w[19:0] || mal !== 0)
            $display("FAIL frame0_tail: got %h (%0d malformed) required %h", rest[19:0], mal, w[19:0]);
        else n_pass++;
    endtask

    task automatic test_full_refresh();
        logic [23:0] word;
        int mal;
        for (int f = 1; f < 8; f++) begin
            n_checks++;
            if (no_of_frame_dbg !== 3'(f) || frame_to_transmit_dbg !== exp_led[f])
                $display("FAIL frame%0d_load: got %0d/%h required %0d/%h", f, no_of_frame_dbg, frame_to_transmit_dbg, f, exp_led[f]);
            else n_pass++;
            receive_bits(23, word, mal);
            n_checks++;
            if (word !== exp_led[f] || mal !== 0)
                $display("FAIL frame%0d_stream: got %h (%0d malformed) required %h", f, word, mal, exp_led[f]);
            else n_pass++;
        end
    endtask

    task automatic test_request();
        n_checks++;
        if (new_frames_set_rqst !== 1'b1 || ncyc - start_ncyc !== REFRESH)
            $display("FAIL request_time: rqst=%b at cycle %0d required 1 at %0d", new_frames_set_rqst, ncyc - start_ncyc, REFRESH);
        else n_pass++;
        n_checks++;
        if (led_stripe_pin !== 1'b0 || no_of_frame_dbg !== 3'd0)
            $display("FAIL request_cycle: pin=%b frame=%0d required 0/0", led_stripe_pin, no_of_frame_dbg);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({new_frames_set_rqst, r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg} !== {1'b0, 1'b1, 1'b0, 16'd0})
            $display("FAIL after_request: got rqst=%b wait=%b pin=%b cnt=%0d required 0/1/0/0",
                     new_frames_set_rqst, r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg);
        else n_pass++;
        n_checks++;
        if (rq_seen !== 1) $display("FAIL request_count: got %0d pulse cycles required 1", rq_seen);
        else n_pass++;
    endtask

    task automatic test_reload();
        logic [23:0] word, v1, v2;
        int mal, lo;
        for (int i = 0; i < 8; i++) begin
            led[i] = 24'($urandom);
            exp_led[i] = led[i];
        end
        v1 = 24'($urandom);
        while (v1 == exp_led[3]) v1 = 24'($urandom);
        v2 = ~v1;
        lo = 0;
        while (led_stripe_pin === 1'b0 && lo < R + 10) begin
            lo++;
            @(negedge clk);
        end
        n_checks++;
        if (lo !== R) $display("FAIL refresh2_latch: got %0d low cycles required %0d", lo, R);
        else n_pass++;
        for (int f = 0; f < 4; f++) begin
            n_checks++;
            if (no_of_frame_dbg !== 3'(f) || frame_to_transmit_dbg !== exp_led[f])
                $display("FAIL r2_frame%0d_load: got %0d/%h required %0d/%h", f, no_of_frame_dbg, frame_to_transmit_dbg, f, exp_led[f]);
            else n_pass++;
            if (f == 2) begin
                fork
                    receive_bits(23, word, mal);
                    begin
                        repeat (1000) @(negedge clk);
                        led[3] = v1;
                        exp_led[3] = v1;
                    end
                join
            end else if (f == 3) begin
                fork
                    receive_bits(23, word, mal);
                    begin
                        repeat (100) @(negedge clk);
                        led[3] = v2;
                    end
                join
            end else begin
                receive_bits(23, word, mal);
            end
            n_checks++;
            if (word !== exp_led[f] || mal !== 0)
                $display("FAIL r2_frame%0d_stream: got %h (%0d malformed) required %h", f, word, mal, exp_led[f]);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_reset();
        logic [23:0] word;
        int mal, lo;
        n_checks++;
        if (no_of_frame_dbg !== 3'd4 || frame_to_transmit_dbg !== exp_led[4])
            $display("FAIL r2_frame4_load: got %0d/%h required 4/%h", no_of_frame_dbg, frame_to_transmit_dbg, exp_led[4]);
        else n_pass++;
        repeat (500) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({led_stripe_pin, new_frames_set_rqst, frame_to_transmit_dbg, no_of_frame_dbg,
             r_time_wait_dbg, l_time_wait_dbg, s_time_wait_dbg,
             reset_finish_dbg, l_time_measured_dbg, s_time_measured_dbg,
             r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg} !== 83'd0)
            $display("FAIL abort_outputs: pin=%b frame=%h idx=%0d cnts=%h required all 0",
                     led_stripe_pin, frame_to_transmit_dbg, no_of_frame_dbg, {r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg});
        else n_pass++;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg, no_of_frame_dbg} !== {1'b1, 1'b0, 16'd0, 3'd0})
            $display("FAIL abort_restart: got wait=%b pin=%b cnt=%0d idx=%0d required 1/0/0/0",
                     r_time_wait_dbg, led_stripe_pin, r_time_cnt_dbg, no_of_frame_dbg);
        else n_pass++;
        lo = 0;
        while (led_stripe_pin === 1'b0 && lo < R + 10) begin
            lo++;
            @(negedge clk);
        end
        n_checks++;
        if (lo !== R) $display("FAIL abort_latch: got %0d low cycles required %0d", lo, R);
        else n_pass++;
        n_checks++;
        if (no_of_frame_dbg !== 3'd0 || frame_to_transmit_dbg !== led[0])
            $display("FAIL abort_frame0_load: got %0d/%h required 0/%h", no_of_frame_dbg, frame_to_transmit_dbg, led[0]);
        else n_pass++;
        receive_bits(23, word, mal);
        n_checks++;
        if (word !== led[0] || mal !== 0)
            $display("FAIL abort_frame0_stream: got %h (%0d malformed) required %h", word, mal, led[0]);
        else n_pass++;
    endtask

    initial begin
        clk = 1'b0;
        rstn = 1'b1;
        exp_led[0] = 24'h111111;
        exp_led[1] = 24'hBBBBBB;
        exp_led[2] = 24'h444444;
        exp_led[3] = 24'h888888;
        exp_led[4] = 24'h999999;
        exp_led[5] = 24'hAAAAAA;
        exp_led[6] = 24'hCCCCCC;
        exp_led[7] = 24'h222222;
        for (int i = 0; i < 8; i++) led[i] = exp_led[i];
        test_reset();
        test_rst_low();
        test_first_bits();
        test_full_refresh();
        test_request();
        test_reload();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
